// File: rtl/uart_tx_queue_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_tx_queue_ctrl_if
// Handshake bundle between the CPU memory stage, the UART TX queue controller
// and the UART transmitter.
//
//   CPU side  : cpu_wr_valid, cpu_wr_data[7:0]  (store to the TX data address)
//               cpu_wr_ready, cpu_stall          (queue back-pressure)
//   UART side : uart_tx_data[7:0], uart_tx_valid (byte at queue head)
//               uart_tx_ready                    (transmitter accepts byte)
//
// Modports:
//   slave  - the queue controller (consumes CPU stores, produces UART bytes)
//   master - the surrounding environment (CPU + transmitter)
// -----------------------------------------------------------------------------
interface uart_tx_queue_ctrl_if;
   logic       cpu_wr_valid;
   logic [7:0] cpu_wr_data;
   logic       cpu_wr_ready;
   logic       cpu_stall;
   logic [7:0] uart_tx_data;
   logic       uart_tx_valid;
   logic       uart_tx_ready;

   modport slave (
      input  cpu_wr_valid,
      input  cpu_wr_data,
      input  uart_tx_ready,
      output cpu_wr_ready,
      output cpu_stall,
      output uart_tx_data,
      output uart_tx_valid
   );

   modport master (
      output cpu_wr_valid,
      output cpu_wr_data,
      output uart_tx_ready,
      input  cpu_wr_ready,
      input  cpu_stall,
      input  uart_tx_data,
      input  uart_tx_valid
   );
endinterface : uart_tx_queue_ctrl_if

// File: rtl/uart_tx_queue_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_queue_ctrl
// Buffers CPU stores to the UART TX data address in a DEPTH-entry FIFO and
// presents them to the UART transmitter through a valid/ready handshake.
// The CPU is stalled while the FIFO is full.
//
// Parameters:
//   DEPTH - FIFO entries, power of two, >= 2
//   CNT_W - width of the stall-cycle (drop) counter
//
// Ports:
//   clk               - rising-edge clock
//   rst_n             - asynchronous active-low reset
//   flush_i           - synchronous clear of the FIFO (wins over push/pop)
//   bus_if            - CPU store / UART TX handshake bundle (slave view)
//   tx_status_ready_o - not-full status bit for the UART control register
//   fifo_count_o      - current occupancy, 0..DEPTH
//   drop_count_o      - saturating count of stalled cycles
//
// Build option:
//   UART_TX_DROP_CNT_EN - when defined, drop_count_o is a saturating counter
//                         of cycles with cpu_stall=1; otherwise it is tied 0.
// -----------------------------------------------------------------------------
module uart_tx_queue_ctrl #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   uart_tx_queue_ctrl_if.slave      bus_if,
   output logic                     tx_status_ready_o,
   output logic [$clog2(DEPTH):0]   fifo_count_o,
   output logic [CNT_W-1:0]         drop_count_o
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_FW = PTR_W + 1;

   localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1'b1);
   localparam logic [PTR_W-1:0]  PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [CNT_FW-1:0] CNT_ONE  = CNT_FW'(1'b1);
   localparam logic [CNT_FW-1:0] CNT_ZERO = {CNT_FW{1'b0}};
   localparam logic [CNT_FW-1:0] CNT_FULL = CNT_FW'(DEPTH);

   // Storage and state
   logic [7:0]        mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_FW-1:0] count_q,  count_d;
   // Registered status flags, kept in step with count_q so the CPU-facing
   // ready and UART-facing valid come straight from flops.
   logic              wr_ready_q, wr_ready_d;
   logic              tx_valid_q, tx_valid_d;

   logic              push_s;
   logic              pop_s;
   logic              stall_s;

   // Handshake qualification; flush suppresses both transfers and the stall.
   always_comb begin
      push_s  = bus_if.cpu_wr_valid & wr_ready_q & ~flush_i;
      pop_s   = tx_valid_q & bus_if.uart_tx_ready & ~flush_i;
      stall_s = bus_if.cpu_wr_valid & ~wr_ready_q & ~flush_i;
   end

   // Pointer, occupancy and status-flag next-state.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      wr_ready_d = wr_ready_q;
      tx_valid_d = tx_valid_q;
      if (flush_i) begin
         wr_ptr_d = PTR_ZERO;
         rd_ptr_d = PTR_ZERO;
         count_d  = CNT_ZERO;
      end else begin
         // Pointers are PTR_W bits wide, so they wrap modulo DEPTH for free.
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
      wr_ready_d = (count_d != CNT_FULL);
      tx_valid_d = (count_d != CNT_ZERO);
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= PTR_ZERO;
         rd_ptr_q   <= PTR_ZERO;
         count_q    <= CNT_ZERO;
         wr_ready_q <= 1'b1;
         tx_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         wr_ready_q <= wr_ready_d;
         tx_valid_q <= tx_valid_d;
      end
   end

   // FIFO storage write; contents are don't-care after reset or flush.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= bus_if.cpu_wr_data;
      end
   end

   // Head of queue is read directly from the registered read pointer, so a
   // byte written at edge N is visible only after that edge (no bypass).
   assign bus_if.uart_tx_data  = mem_q[rd_ptr_q];
   assign bus_if.uart_tx_valid = tx_valid_q;
   assign bus_if.cpu_wr_ready  = wr_ready_q;
   assign bus_if.cpu_stall     = stall_s;
   assign tx_status_ready_o    = wr_ready_q;
   assign fifo_count_o         = count_q;

`ifdef UART_TX_DROP_CNT_EN
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   // Saturating stall-cycle counter; flush clears it ahead of any increment.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (flush_i) begin
         drop_cnt_d = {CNT_W{1'b0}};
      end else if (stall_s && (drop_cnt_q != {CNT_W{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + CNT_W'(1'b1);
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   // Drop counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q <= {CNT_W{1'b0}};
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_count_o = drop_cnt_q;
`else
   assign drop_count_o = {CNT_W{1'b0}};
`endif

endmodule : uart_tx_queue_ctrl

// File: doc/uart_tx_queue_ctrl.md
Name: uart_tx_queue_ctrl

Overview:
- Schedules CPU stores to the UART TX data address (0x80000008) onto the UART transmitter.
- Sits between the memory-stage decode strobe (tx data-in valid) and the UART TX valid/ready port.
- Buffers bytes in a DEPTH-entry FIFO and issues a stall when the buffer is full.
- Exports a not-full status bit for the UART control register read (0x80000000) and an occupancy count.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of optional drop counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_wr_valid  in  1  memory-stage store to 0x80000008 this cycle.
- cpu_wr_data  in  8  store byte (rs2[7:0]).
- cpu_wr_ready  out  1  FIFO can accept a push this cycle.
- cpu_stall  out  1  cpu_wr_valid & ~cpu_wr_ready; holds the pipeline.
- flush  in  1  synchronous clear of FIFO contents (software reset / io_reset).
- uart_tx_data  out  8  byte at FIFO head.
- uart_tx_valid  out  1  FIFO non-empty.
- uart_tx_ready  in  1  transmitter accepts byte.
- tx_status_ready  out  1  ~full; read as UART control bit 0.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- drop_count  out  CNT_W  stall-cycle counter (see Optional Feature).

Behaviour:
- Reset (rst_n=0, async):
  - rd_ptr=wr_ptr=0, count=0, storage contents don't-care.
  - uart_tx_valid=0, cpu_wr_ready=1, tx_status_ready=1, fifo_count=0, drop_count=0, cpu_stall=0.
- Deassertion of reset is synchronous to clk; the first push is possible on the first edge after release.
- Reset asserted mid-transfer: the in-flight byte is discarded, with no partial handshake completion.
- Push: cpu_wr_valid & cpu_wr_ready at a rising edge writes cpu_wr_data at wr_ptr; wr_ptr increments.
- Pop: uart_tx_valid & uart_tx_ready at a rising edge increments rd_ptr.
- Count:
  - push only: +1.
  - pop only: -1.
  - both: unchanged; both pointers advance.
- Pointers: $clog2(DEPTH) bits and wrap modulo DEPTH (7 -> 0 for DEPTH=8). Full/empty are derived from count, not from pointer equality.
- cpu_wr_ready = (count != DEPTH).
  - Depends only on state, not on uart_tx_ready, so there is no combinational path from the UART to the CPU stall.
  - When full with a simultaneous pop, a push is still refused that cycle and succeeds the next cycle.
- uart_tx_valid = (count != 0). uart_tx_data = mem[rd_ptr], driven combinationally from the registered pointer.
- Latency: a byte pushed at edge N is presented on uart_tx_data with uart_tx_valid=1 in the cycle after edge N. There is no same-cycle bypass.
- Empty plus push: valid rises next cycle; no pop happens this cycle.
- Valid/data hold rule: once uart_tx_valid=1, uart_tx_data remains stable until popped, except on flush.
- cpu_stall is combinational: cpu_wr_valid & (count==DEPTH). The CPU holds cpu_wr_valid/cpu_wr_data stable while stalled.
- flush:
  - Has priority over push and pop in the same cycle; the push is lost and cpu_stall is forced 0 that cycle.
  - Next cycle: count=0, pointers=0, uart_tx_valid=0.
- tx_status_ready = cpu_wr_ready.
- fifo_count = count (registered).

Optional Feature:
- Macro UART_TX_DROP_CNT_EN.
- When defined:
  - drop_count is a CNT_W-bit register that increments on every cycle with cpu_stall=1.
  - It saturates at all-ones (no wrap).
  - It clears on flush or reset; flush has priority over increment.
- When undefined: drop_count is tied to 0 and no counter register is synthesised.

Test Plan:
- Reset then idle -> uart_tx_valid=0, cpu_wr_ready=1, fifo_count=0, tx_status_ready=1. Assert rst_n=0 asynchronously mid-cycle with count=3 -> all outputs return to reset values immediately.
- uart_tx_ready=0; push 0x41,0x42,...,0x48 on consecutive cycles (DEPTH=8) -> fifo_count=8, cpu_wr_ready=0. 9th push 0x49 -> cpu_stall=1 and no write. Raise uart_tx_ready -> stall drops one cycle after the first pop; 0x49 is accepted.
- uart_tx_ready=1 held; push 0x55 at edge N -> uart_tx_valid=1 and data=0x55 in cycle N+1; popped at edge N+1; fifo_count returns to 0.
- Continuous push and pop for 20 bytes 0x00..0x13 with uart_tx_ready toggling 1,0 -> output order is exactly 0x00..0x13, pointers wrap twice, and fifo_count never exceeds 8.
- count=5, flush=1 together with cpu_wr_valid=1 (0x7E) -> next cycle count=0, uart_tx_valid=0. 0x7E is never transmitted.
- With UART_TX_DROP_CNT_EN defined: hold the FIFO full and cpu_wr_valid=1 for 10 cycles -> drop_count=10. Force CNT_W=4 and hold 20 cycles -> drop_count=15. Flush -> drop_count=0. Without the macro, drop_count stays 0 throughout.
